// File: rtl/spi_ram_master_if.sv
// Host command port and SPI pins of the SPI RAM initiator, bundled as one interface.
// master = initiator side, slave = host/slave side.
interface spi_ram_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       SS_n;
  logic       SCLK;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, MISO,
    output cmd_ready, rd_data, rd_valid, busy, SS_n, SCLK, MOSI
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, MISO,
    input  cmd_ready, rd_data, rd_valid, busy, SS_n, SCLK, MOSI
  );
endinterface

// File: rtl/spi_ram_master.sv
// Mode-0 SPI initiator: one SS_n-framed transfer per host command, with an 8-bit
// read-back after a dummy turnaround for the read-data opcode.
module spi_ram_master #(
  parameter int CLK_DIV  = 2,
  parameter int TURN_CYC = 1,
  parameter int GAP_CYC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_ram_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SHIFT, TURN, READ, GAP} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] TURN_LAST = 16'(TURN_CYC - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sclk_q, sclk_d;
  logic        ss_n_q, ss_n_d;
  logic        mosi_q, mosi_d;
  logic [9:0]  tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        is_rd_q, is_rd_d;

  logic tick, sclk_rise, sclk_fall;

  assign tick      = (div_q == DIV_LAST);
  assign sclk_rise = tick && !sclk_q;
  assign sclk_fall = tick && sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_q      <= '0;
      cnt_q      <= '0;
      sclk_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      tx_q       <= '0;
      rx_q       <= '0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      is_rd_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sclk_q     <= sclk_d;
      ss_n_q     <= ss_n_d;
      mosi_q     <= mosi_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      is_rd_q    <= is_rd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    sclk_d     = sclk_q;
    ss_n_d     = ss_n_q;
    mosi_d     = mosi_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    is_rd_d    = is_rd_q;

    // SCLK divider runs only inside a frame so SCLK cannot move while SS_n is high
    if (state_q == SHIFT || state_q == TURN || state_q == READ) begin
      if (tick) begin
        div_d  = '0;
        sclk_d = !sclk_q;
      end else begin
        div_d = div_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        sclk_d = 1'b0;
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        if (bus.cmd_valid) begin
          tx_d    = {bus.cmd_op, bus.cmd_data};
          is_rd_d = (bus.cmd_op == 2'b11);
          mosi_d  = bus.cmd_op[1];
          ss_n_d  = 1'b0;
          div_d   = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_fall) begin
          if (cnt_q == 16'd9) begin
            cnt_d  = '0;
            mosi_d = 1'b0;
            if (is_rd_q) begin
              state_d = TURN;
            end else begin
              ss_n_d  = 1'b1;
              state_d = GAP;
            end
          end else begin
            cnt_d  = cnt_q + 16'd1;
            mosi_d = tx_q[8];
            tx_d   = {tx_q[8:0], 1'b0};
          end
        end
      end

      TURN: begin
        mosi_d = 1'b0;
        if (sclk_fall) begin
          if (cnt_q == TURN_LAST) begin
            cnt_d   = '0;
            rx_d    = '0;
            state_d = READ;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      READ: begin
        mosi_d = 1'b0;
        if (sclk_rise) begin
          rx_d = {rx_q[6:0], bus.MISO};
        end
        // SS_n release and the read-back strobe share the final falling SCLK edge
        if (sclk_fall) begin
          if (cnt_q == 16'd7) begin
            cnt_d      = '0;
            ss_n_d     = 1'b1;
            rd_data_d  = rx_q;
            rd_valid_d = 1'b1;
            state_d    = GAP;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end

      GAP: begin
        sclk_d = 1'b0;
        ss_n_d = 1'b1;
        mosi_d = 1'b0;
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.SS_n      = ss_n_q;
  assign bus.SCLK      = sclk_q;
  assign bus.MOSI      = mosi_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_spi_ram_master.sv
// Directed bench for spi_ram_master: default-parameter DUT against a slave+RAM model,
// plus a CLK_DIV=1/TURN_CYC=2 instance with MISO tied high.
module tb_spi_ram_master;
  localparam int TURN1 = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_ram_master_if if1 ();
  spi_ram_master_if if2 ();

  spi_ram_master #(.CLK_DIV(2), .TURN_CYC(TURN1), .GAP_CYC(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.master)
  );
  spi_ram_master #(.CLK_DIV(1), .TURN_CYC(2), .GAP_CYC(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Slave + RAM model: captures the 10-bit command on rising SCLK, answers reads after the turnaround
  logic       miso1 = 1'b0;
  logic [9:0] cap = '0;
  int         rise_n = 0;
  int         fall_n = 0;
  logic [7:0] sl_addr = 8'h00;
  logic [7:0] sl_tx = 8'h00;
  logic [7:0] mem [256];
  logic       ss_prev = 1'b1;
  logic       sclk_prev = 1'b0;

  assign if1.MISO = miso1;
  assign if2.MISO = 1'b1;

  always @(if1.SS_n or if1.SCLK) begin
    if (ss_prev === 1'b1 && if1.SS_n === 1'b0) begin
      rise_n = 0;
      fall_n = 0;
      cap    = '0;
    end
    if (sclk_prev === 1'b0 && if1.SCLK === 1'b1) begin
      if (rise_n < 10) cap = {cap[8:0], if1.MOSI};
      rise_n++;
    end else if (sclk_prev === 1'b1 && if1.SCLK === 1'b0) begin
      fall_n++;
      if (fall_n == 10) begin
        case (cap[9:8])
          2'b00:   sl_addr = cap[7:0];
          2'b01:   mem[sl_addr] = cap[7:0];
          2'b10:   sl_addr = cap[7:0];
          default: ;
        endcase
      end
      if (cap[9:8] == 2'b11 && fall_n == 10 + TURN1) begin
        sl_tx = mem[sl_addr];
        miso1 = sl_tx[7];
      end else if (cap[9:8] == 2'b11 && fall_n > 10 + TURN1) begin
        sl_tx = {sl_tx[6:0], 1'b0};
        miso1 = sl_tx[7];
      end
    end
    ss_prev   = if1.SS_n;
    sclk_prev = if1.SCLK;
  end

  // Frame monitors, sampled on the falling clk edge; the bench only takes deltas
  int   ss_low = 0, frames = 0, hi_run = 0, last_gap = 0;
  int   rdv_cnt = 0, rdv_bad = 0, sclk_bad = 0;
  logic prev_ss = 1'b1;
  int   cyc = 0, ss2_low = 0, rdv2_cnt = 0, last_rise2 = 0, period2 = 0;
  logic prev_sclk2 = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (if1.SS_n === 1'b0) begin
      if (prev_ss === 1'b1) begin
        frames++;
        last_gap = hi_run;
      end
      ss_low++;
      hi_run = 0;
    end else begin
      hi_run++;
    end
    if (if1.rd_valid === 1'b1) begin
      rdv_cnt++;
      if (!(if1.SS_n === 1'b1 && prev_ss === 1'b0)) rdv_bad++;
    end
    if (if1.SS_n === 1'b1 && if1.SCLK === 1'b1) sclk_bad++;
    prev_ss = if1.SS_n;
    if (if2.SS_n === 1'b0) ss2_low++;
    if (if2.rd_valid === 1'b1) rdv2_cnt++;
    if (prev_sclk2 === 1'b0 && if2.SCLK === 1'b1) begin
      period2    = cyc - last_rise2;
      last_rise2 = cyc;
    end
    prev_sclk2 = if2.SCLK;
  end

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    logic [9:0] bits;
    int         low;
    int         rdv;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs [8];

  task automatic send1(input logic [1:0] op, input logic [7:0] data);
    int n = 0;
    @(negedge clk);
    if1.cmd_valid = 1'b1;
    if1.cmd_op    = op;
    if1.cmd_data  = data;
    while (if1.cmd_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", (n < 1000), 1);
    @(negedge clk);
    // scramble inputs after acceptance; the frame must not change
    if1.cmd_valid = 1'b0;
    if1.cmd_op    = ~op;
    if1.cmd_data  = ~data;
  endtask

  task automatic wait_idle1(input string nm);
    int n = 0;
    while (if1.busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_idle_timeout"}, (n < 5000), 1);
    chk({nm, "_ready"}, if1.cmd_ready, 1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int s_low, s_fr, s_rdv, s_bad;
    string nm;
    nm    = $sformatf("v%0d", idx);
    s_low = ss_low; s_fr = frames; s_rdv = rdv_cnt; s_bad = rdv_bad;
    send1(v.op, v.data);
    wait_idle1(nm);
    chk({nm, "_bits"},   cap, v.bits);
    chk({nm, "_ss_low"}, ss_low - s_low, v.low);
    chk({nm, "_rdv"},    rdv_cnt - s_rdv, v.rdv);
    chk({nm, "_rdv_at_ss_rise"}, rdv_bad - s_bad, 0);
    chk({nm, "_frames"}, frames - s_fr, 1);
    chk({nm, "_rises"},  rise_n, (v.op == 2'b11) ? 10 + TURN1 + 8 : 10);
    chk({nm, "_rd_data"}, if1.rd_data, v.rd);
    $display("vec %0d op=%b data=%h bits=%h ss_low=%0d rd_data=%h", idx, v.op, v.data,
             cap, ss_low - s_low, if1.rd_data);
  endtask

  initial begin
    int s_fr, s_low, s_rdv, n;
    vecs[0] = '{2'b00, 8'h3C, 10'h03C, 40, 0, 8'h00};
    vecs[1] = '{2'b01, 8'hA5, 10'h1A5, 40, 0, 8'h00};
    vecs[2] = '{2'b11, 8'h00, 10'h300, 76, 1, 8'hA5};
    vecs[3] = '{2'b00, 8'h10, 10'h010, 40, 0, 8'hA5};
    vecs[4] = '{2'b01, 8'h5A, 10'h15A, 40, 0, 8'hA5};
    vecs[5] = '{2'b10, 8'h10, 10'h210, 40, 0, 8'hA5};
    vecs[6] = '{2'b11, 8'h00, 10'h300, 76, 1, 8'h5A};
    vecs[7] = '{2'b11, 8'h00, 10'h300, 76, 1, 8'h5A};

    if1.cmd_valid = 1'b0; if1.cmd_op = 2'b00; if1.cmd_data = 8'h00;
    if2.cmd_valid = 1'b0; if2.cmd_op = 2'b00; if2.cmd_data = 8'h00;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ss_n", if1.SS_n, 1);
    chk("rst_sclk", if1.SCLK, 0);
    chk("rst_mosi", if1.MOSI, 0);
    chk("rst_busy", if1.busy, 0);
    chk("rst_ready", if1.cmd_ready, 1);
    chk("rst_rd_data", if1.rd_data, 8'h00);
    chk("rst_rd_valid", if1.rd_valid, 0);
    $display("reset: SS_n=%b SCLK=%b busy=%b ready=%b", if1.SS_n, if1.SCLK, if1.busy, if1.cmd_ready);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // command pulsed mid-frame is ignored
    s_fr = frames; s_low = ss_low;
    send1(2'b00, 8'h10);
    n = 0;
    while (rise_n < 3 && n < 500) begin @(negedge clk); n++; end
    chk("ign_wait", (n < 500), 1);
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b01; if1.cmd_data = 8'hEE;
    chk("ign_ready", if1.cmd_ready, 0);
    @(negedge clk);
    if1.cmd_valid = 1'b0;
    wait_idle1("ign");
    repeat (10) @(negedge clk);
    chk("ign_bits", cap, 10'h010);
    chk("ign_frames", frames - s_fr, 1);
    chk("ign_ss_low", ss_low - s_low, 40);
    $display("ignore: frames=%0d bits=%h", frames - s_fr, cap);

    // back-to-back: command held valid through GAP
    s_fr = frames;
    @(negedge clk);
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b10; if1.cmd_data = 8'h10;
    n = 0;
    while (frames - s_fr < 2 && n < 500) begin @(negedge clk); n++; end
    if1.cmd_valid = 1'b0;
    chk("b2b_wait", (n < 500), 1);
    chk("b2b_gap", last_gap, 5);
    wait_idle1("b2b");
    chk("b2b_frames", frames - s_fr, 2);
    $display("back2back: frames=%0d gap=%0d", frames - s_fr, last_gap);

    // asynchronous reset in the middle of a read frame
    s_rdv = rdv_cnt;
    send1(2'b11, 8'h00);
    n = 0;
    while (rise_n < 5 && n < 500) begin @(negedge clk); n++; end
    chk("arst_wait", (n < 500), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ss_n", if1.SS_n, 1);
    chk("arst_sclk", if1.SCLK, 0);
    chk("arst_mosi", if1.MOSI, 0);
    chk("arst_busy", if1.busy, 0);
    chk("arst_ready", if1.cmd_ready, 1);
    chk("arst_rd_data", if1.rd_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arst_rdv", rdv_cnt - s_rdv, 0);
    $display("async reset: SS_n=%b SCLK=%b busy=%b rd_data=%h", if1.SS_n, if1.SCLK, if1.busy, if1.rd_data);
    run_vec(7, vecs[7]);
    chk("sclk_while_ss_high", sclk_bad, 0);

    // CLK_DIV=1, TURN_CYC=2 instance, MISO tied high
    s_low = ss2_low; s_rdv = rdv2_cnt;
    @(negedge clk);
    if2.cmd_valid = 1'b1; if2.cmd_op = 2'b11; if2.cmd_data = 8'h00;
    chk("d2_ready", if2.cmd_ready, 1);
    @(negedge clk);
    if2.cmd_valid = 1'b0;
    n = 0;
    while (if2.busy === 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk("d2_timeout", (n < 2000), 1);
    chk("d2_ss_low", ss2_low - s_low, 40);
    chk("d2_sclk_period", period2, 2);
    chk("d2_rd_data", if2.rd_data, 8'hFF);
    chk("d2_rdv", rdv2_cnt - s_rdv, 1);
    $display("div1: ss_low=%0d period=%0d rd_data=%h", ss2_low - s_low, period2, if2.rd_data);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
